// File: rtl/y86_seq_ctrl.sv
// y86_seq_ctrl: multi-cycle stage sequencer for the sequential Y86-64 core.
// Owns the PC, walks each instruction through six one-hot stage enables,
// waits on the data-memory handshake and keeps the processor status code.
//
// Memory handshake: while in MEMORY for a memory-touching icode the request
// is implicitly outstanding; the access completes in the first cycle that
// mem_ready=1, and only in that cycle are valM and dmem_error meaningful.
// A completion arriving in the final allowed wait cycle wins over timeout.
module y86_seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        cnd,
    input  logic [63:0] valM,
    input  logic        mem_ready,
    input  logic        dmem_error,
    output logic [63:0] PC,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic        pc_en,
    output logic [1:0]  stat,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PCUPD     = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    // Wait counter runs 0..MEM_TIMEOUT-1; the last value is the final allowed cycle.
    localparam int            CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state, state_n;
    logic [63:0]   pc_n;
    logic [1:0]    stat_n;
    logic          halted_n;
    logic [31:0]   count_n;
    logic [3:0]    icode_r, icode_n;
    logic [63:0]   valc_r, valc_n;
    logic [63:0]   valp_r, valp_n;
    logic [63:0]   valm_r, valm_n;
    logic          cnd_r, cnd_n;
    logic [CW-1:0] wait_r, wait_n;
    logic          mem_op;

    // Instructions that touch data memory and must wait for the handshake.
    assign mem_op = (icode_r == 4'h4) || (icode_r == 4'h5) || (icode_r == 4'h8) ||
                    (icode_r == 4'h9) || (icode_r == 4'hA) || (icode_r == 4'hB);

    // State and architectural registers; reset overrides any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            PC          <= RESET_PC;
            stat        <= STAT_AOK;
            halted      <= 1'b0;
            instr_count <= 32'd0;
            icode_r     <= 4'h0;
            valc_r      <= 64'h0;
            valp_r      <= 64'h0;
            valm_r      <= 64'h0;
            cnd_r       <= 1'b0;
            wait_r      <= '0;
        end else begin
            state       <= state_n;
            PC          <= pc_n;
            stat        <= stat_n;
            halted      <= halted_n;
            instr_count <= count_n;
            icode_r     <= icode_n;
            valc_r      <= valc_n;
            valp_r      <= valp_n;
            valm_r      <= valm_n;
            cnd_r       <= cnd_n;
            wait_r      <= wait_n;
        end
    end

    // Next-state, latched operands and status; everything holds by default.
    always_comb begin
        state_n  = state;
        pc_n     = PC;
        stat_n   = stat;
        halted_n = halted;
        count_n  = instr_count;
        icode_n  = icode_r;
        valc_n   = valc_r;
        valp_n   = valp_r;
        valm_n   = valm_r;
        cnd_n    = cnd_r;
        wait_n   = wait_r;
        case (state)
            S_FETCH: begin
                if (imem_error) begin
                    stat_n   = STAT_ADR;
                    halted_n = 1'b1;
                    state_n  = S_HALT;
                end else if (!instr_valid) begin
                    stat_n   = STAT_INS;
                    halted_n = 1'b1;
                    state_n  = S_HALT;
                end else if (icode == 4'h0) begin
                    stat_n   = STAT_HLT;
                    halted_n = 1'b1;
                    state_n  = S_HALT;
                end else begin
                    icode_n = icode;
                    valc_n  = valC;
                    valp_n  = valP;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: state_n = S_EXECUTE;
            S_EXECUTE: begin
                cnd_n   = cnd;
                wait_n  = '0;
                state_n = S_MEMORY;
            end
            S_MEMORY: begin
                if (!mem_op) begin
                    state_n = S_WRITEBACK;
                end else if (mem_ready) begin
                    valm_n = valM;
                    if (dmem_error) begin
                        stat_n   = STAT_ADR;
                        halted_n = 1'b1;
                        state_n  = S_HALT;
                    end else begin
                        state_n = S_WRITEBACK;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    stat_n   = STAT_ADR;
                    halted_n = 1'b1;
                    state_n  = S_HALT;
                end else begin
                    wait_n = wait_r + CW'(1);
                end
            end
            S_WRITEBACK: state_n = S_PCUPD;
            S_PCUPD: begin
                if (icode_r == 4'h8) begin
                    pc_n = valc_r;
                end else if ((icode_r == 4'h7) && cnd_r) begin
                    pc_n = valc_r;
                end else if (icode_r == 4'h9) begin
                    pc_n = valm_r;
                end else begin
                    pc_n = valp_r;
                end
                count_n = instr_count + 32'd1;
                state_n = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    // Moore decode of the one-hot stage enables; all low in HALT.
    always_comb begin
        f_en  = 1'b0;
        d_en  = 1'b0;
        e_en  = 1'b0;
        m_en  = 1'b0;
        w_en  = 1'b0;
        pc_en = 1'b0;
        case (state)
            S_FETCH:     f_en  = 1'b1;
            S_DECODE:    d_en  = 1'b1;
            S_EXECUTE:   e_en  = 1'b1;
            S_MEMORY:    m_en  = 1'b1;
            S_WRITEBACK: w_en  = 1'b1;
            S_PCUPD:     pc_en = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// tb_y86_seq_ctrl: instruction-level reference model for the Y86-64 stage
// sequencer, driving directed cases then randomized instruction streams.
module tb_y86_seq_ctrl;

    localparam int TO = 8;
    localparam int W  = 106;

    localparam logic [5:0] EN_F = 6'b100000;
    localparam logic [5:0] EN_D = 6'b010000;
    localparam logic [5:0] EN_E = 6'b001000;
    localparam logic [5:0] EN_M = 6'b000100;
    localparam logic [5:0] EN_W = 6'b000010;
    localparam logic [5:0] EN_P = 6'b000001;
    localparam logic [5:0] EN_0 = 6'b000000;

    localparam logic [1:0] AOK = 2'b00;
    localparam logic [1:0] HLT = 2'b01;
    localparam logic [1:0] ADR = 2'b10;
    localparam logic [1:0] INS = 2'b11;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        cnd;
    logic [63:0] valM;
    logic        mem_ready;
    logic        dmem_error;
    logic [63:0] PC;
    logic        f_en, d_en, e_en, m_en, w_en, pc_en;
    logic [1:0]  stat;
    logic        halted;
    logic [31:0] instr_count;

    y86_seq_ctrl #(
        .RESET_PC    (64'h0),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .valC        (valC),
        .valP        (valP),
        .cnd         (cnd),
        .valM        (valM),
        .mem_ready   (mem_ready),
        .dmem_error  (dmem_error),
        .PC          (PC),
        .f_en        (f_en),
        .d_en        (d_en),
        .e_en        (e_en),
        .m_en        (m_en),
        .w_en        (w_en),
        .pc_en       (pc_en),
        .stat        (stat),
        .halted      (halted),
        .instr_count (instr_count)
    );

    // reference model state (architectural view)
    logic [63:0] m_pc;
    logic [1:0]  m_stat;
    logic        m_halted;
    logic [31:0] m_cnt;

    int checks   = 0;
    int failures = 0;

    // scoreboard: one entry per cycle, MSB marks a checked cycle
    logic [W-1:0] exp_q[$];
    logic [W-2:0] got;
    assign got = {f_en, d_en, e_en, m_en, w_en, pc_en, PC, stat, halted, instr_count};

    function automatic logic is_mem(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
               (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    endfunction

    function automatic logic [63:0] next_pc(input logic [3:0] ic, input logic c,
                                            input logic [63:0] vc, input logic [63:0] vp,
                                            input logic [63:0] vm);
        if (ic == 4'h8) return vc;
        if (ic == 4'h7 && c) return vc;
        if (ic == 4'h9) return vm;
        return vp;
    endfunction

    // compare process: every cycle, just after the driver posts its expectation
    always begin
        logic [W-1:0] r;
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            if (r[W-1]) begin
                checks++;
                if (got !== r[W-2:0]) begin
                    failures++;
                    $display("FAIL cycle_cmp t=%0t got en=%b pc=%h stat=%b halted=%b cnt=%0d exp en=%b pc=%h stat=%b halted=%b cnt=%0d",
                             $time, got[104:99], got[98:35], got[34:33], got[32], got[31:0],
                             r[104:99], r[98:35], r[34:33], r[32], r[31:0]);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic scramble_inputs();
        icode       = 4'($urandom_range(0, 15));
        instr_valid = 1'($urandom_range(0, 1));
        imem_error  = 1'($urandom_range(0, 1));
        valC        = {$urandom, $urandom};
        valP        = {$urandom, $urandom};
        cnd         = 1'($urandom_range(0, 1));
        valM        = {$urandom, $urandom};
        mem_ready   = 1'($urandom_range(0, 1));
        dmem_error  = 1'($urandom_range(0, 1));
    endtask

    task automatic next_cycle(input logic [5:0] en);
        @(negedge clk);
        exp_q.push_back({1'b1, en, m_pc, m_stat, m_halted, m_cnt});
        reset = 1'b0;
        scramble_inputs();
    endtask

    task automatic skip_cycle();
        @(negedge clk);
        exp_q.push_back('0);
        reset = 1'b1;
        scramble_inputs();
    endtask

    // reset asserted from now for this cycle plus n more
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) skip_cycle();
        m_pc     = 64'h0;
        m_stat   = AOK;
        m_halted = 1'b0;
        m_cnt    = 32'd0;
    endtask

    task automatic halt_model(input logic [1:0] s);
        m_stat   = s;
        m_halted = 1'b1;
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) next_cycle(EN_0);
    endtask

    task automatic run_instr(input logic [3:0] ic, input logic iv, input logic ie,
                             input logic [63:0] vc, input logic [63:0] vp, input logic c,
                             input int delay, input logic derr, input logic [63:0] vm);
        int k;
        logic done;
        next_cycle(EN_F);
        icode = ic; instr_valid = iv; imem_error = ie; valC = vc; valP = vp;
        if (ie) begin halt_model(ADR); return; end
        if (!iv) begin halt_model(INS); return; end
        if (ic == 4'h0) begin halt_model(HLT); return; end
        next_cycle(EN_D);
        next_cycle(EN_E);
        cnd = c;
        if (is_mem(ic)) begin
            k = 0;
            done = 1'b0;
            while (!done) begin
                next_cycle(EN_M);
                if (k < delay) begin
                    mem_ready = 1'b0;
                    if (k == TO - 1) begin halt_model(ADR); return; end
                    k++;
                end else begin
                    mem_ready  = 1'b1;
                    dmem_error = derr;
                    valM       = vm;
                    if (derr) begin halt_model(ADR); return; end
                    done = 1'b1;
                end
            end
        end else begin
            next_cycle(EN_M);
        end
        next_cycle(EN_W);
        next_cycle(EN_P);
        m_pc  = next_pc(ic, c, vc, vp, vm);
        m_cnt = m_cnt + 32'd1;
    endtask

    // literal architectural checks right after the next active edge
    task automatic check_after_edge(input string name, input logic [63:0] e_pc,
                                    input logic [1:0] e_stat, input logic e_halted,
                                    input logic [31:0] e_cnt);
        @(posedge clk);
        #1;
        check_lit({name, "_pc"}, PC, e_pc);
        check_lit({name, "_stat"}, {62'h0, stat}, {62'h0, e_stat});
        check_lit({name, "_halted"}, {63'h0, halted}, {63'h0, e_halted});
        check_lit({name, "_cnt"}, {32'h0, instr_count}, {32'h0, e_cnt});
    endtask

    initial begin
        logic [3:0]  ic;
        logic        iv, ie, c, derr;
        logic [63:0] vc, vp, vm;
        int          delay;

        reset = 1'b1;
        scramble_inputs();
        m_pc = 64'h0; m_stat = AOK; m_halted = 1'b0; m_cnt = 32'd0;
        do_reset(2);

        // reset in the middle of EXECUTE
        run_instr(4'h1, 1, 0, 64'h0, 64'h5, 0, 0, 0, 64'h0);
        check_after_edge("pre_rst", 64'h5, AOK, 1'b0, 32'd1);
        next_cycle(EN_F);
        icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0; valP = 64'h6;
        next_cycle(EN_D);
        next_cycle(EN_E);
        do_reset(1);
        check_after_edge("rst", 64'h0, AOK, 1'b0, 32'd0);
        check_lit("rst_f_en", {63'h0, f_en}, 64'h1);

        // two nops
        run_instr(4'h1, 1, 0, 64'h0, 64'h1, 0, 0, 0, 64'h0);
        check_after_edge("nop1", 64'h1, AOK, 1'b0, 32'd1);
        run_instr(4'h1, 1, 0, 64'h0, 64'h2, 0, 0, 0, 64'h0);
        check_after_edge("nop2", 64'h2, AOK, 1'b0, 32'd2);

        // jXX taken / not taken
        run_instr(4'h7, 1, 0, 64'h40, 64'h9, 1, 0, 0, 64'h0);
        check_after_edge("jxx_taken", 64'h40, AOK, 1'b0, 32'd3);
        run_instr(4'h7, 1, 0, 64'h40, 64'h9, 0, 0, 0, 64'h0);
        check_after_edge("jxx_not", 64'h9, AOK, 1'b0, 32'd4);

        // ret with a three-cycle memory wait
        run_instr(4'h9, 1, 0, 64'h77, 64'ha, 0, 3, 0, 64'h100);
        check_after_edge("ret", 64'h100, AOK, 1'b0, 32'd5);

        // call goes to valC
        run_instr(4'h8, 1, 0, 64'h20, 64'h109, 0, 1, 0, 64'h55);
        check_after_edge("call", 64'h20, AOK, 1'b0, 32'd6);

        // halt at 0x20, frozen afterwards
        run_instr(4'h0, 1, 0, 64'h0, 64'h21, 0, 0, 0, 64'h0);
        check_after_edge("halt", 64'h20, HLT, 1'b1, 32'd6);
        halt_cycles(20);
        check_after_edge("halt_hold", 64'h20, HLT, 1'b1, 32'd6);

        // fetch errors
        do_reset(1);
        run_instr(4'h1, 1, 1, 64'h0, 64'h1, 0, 0, 0, 64'h0);
        check_after_edge("imem_err", 64'h0, ADR, 1'b1, 32'd0);
        do_reset(1);
        run_instr(4'h1, 0, 0, 64'h0, 64'h1, 0, 0, 0, 64'h0);
        check_after_edge("ins_err", 64'h0, INS, 1'b1, 32'd0);
        do_reset(1);
        run_instr(4'h0, 0, 1, 64'h0, 64'h1, 0, 0, 0, 64'h0);
        check_after_edge("both_err", 64'h0, ADR, 1'b1, 32'd0);

        // memory timeout, then ready on the final allowed cycle, then dmem error
        do_reset(1);
        run_instr(4'h1, 1, 0, 64'h0, 64'h3, 0, 0, 0, 64'h0);
        run_instr(4'h5, 1, 0, 64'h0, 64'hd, 0, 100, 0, 64'h0);
        check_after_edge("timeout", 64'h3, ADR, 1'b1, 32'd1);
        halt_cycles(3);
        do_reset(1);
        run_instr(4'h5, 1, 0, 64'h0, 64'ha, 0, TO - 1, 0, 64'h0);
        check_after_edge("late_ready", 64'ha, AOK, 1'b0, 32'd1);
        run_instr(4'hA, 1, 0, 64'h0, 64'hc, 0, 2, 1, 64'h0);
        check_after_edge("dmem_err", 64'ha, ADR, 1'b1, 32'd1);
        halt_cycles(2);

        // randomized instruction stream
        do_reset(1);
        repeat (300) begin
            if (m_halted) begin
                halt_cycles($urandom_range(1, 3));
                do_reset($urandom_range(0, 2));
            end
            ic    = ($urandom_range(0, 11) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            iv    = ($urandom_range(0, 19) != 0);
            ie    = ($urandom_range(0, 29) == 0);
            vc    = {$urandom, $urandom};
            vp    = {$urandom, $urandom};
            vm    = {$urandom, $urandom};
            c     = 1'($urandom_range(0, 1));
            derr  = ($urandom_range(0, 14) == 0);
            delay = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2)
                                                : $urandom_range(0, 3);
            run_instr(ic, iv, ie, vc, vp, c, delay, derr, vm);
        end
        next_cycle(m_halted ? EN_0 : EN_F);

        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/y86_seq_ctrl.md
# y86_seq_ctrl

Multi-cycle stage sequencer for the sequential Y86-64 processor. It owns the program counter and steps each instruction through the fetch, decode, execute, memory, writeback and PC-update stages. It waits on a data-memory ready handshake for memory-touching instructions and maintains the processor status code, stopping the machine on halt or on any error. It sits above the fetch unit (driving its PC input) and gates every stage's state update through one-hot stage enables.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- MEM_TIMEOUT, 16, maximum wait cycles in MEMORY for mem_ready before raising ADR (≥1)
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- icode  in  4  instruction code from fetch
- instr_valid  in  1  fetch decoded a legal instruction
- imem_error  in  1  fetch address out of range
- valC  in  64  constant word from fetch
- valP  in  64  fall-through PC from fetch
- cnd  in  1  condition result from execute
- valM  in  64  data-memory read value
- mem_ready  in  1  data memory completed access this cycle
- dmem_error  in  1  data memory address error, qualified by mem_ready
- PC  out  64  current instruction address, registered
- f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  one-hot stage enables
- stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS, registered
- halted  out  1  machine stopped, registered
- instr_count  out  32  retired-instruction counter, registered

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. Stage enables are a Moore decode of state; all are 0 in HALT.
- Reset (overrides everything, including mid-instruction): state=FETCH, PC=RESET_PC, stat=AOK, halted=0, instr_count=0.
- FETCH: sample icode, valC, valP, instr_valid and imem_error. Priority is imem_error → stat=ADR, then !instr_valid → INS, then icode==0 → HLT. On any of these, go to HALT with halted=1 and PC unchanged. Otherwise latch icode/valC/valP and go to DECODE.
- DECODE → EXECUTE unconditionally. EXECUTE latches cnd and goes to MEMORY.
- MEMORY, for memory icodes (4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq):
  - Hold until mem_ready=1, counting wait cycles.
  - When mem_ready=1: latch valM. If dmem_error=1, stat=ADR and go to HALT; otherwise go to WRITEBACK.
  - If the count reaches MEM_TIMEOUT without mem_ready: stat=ADR, go to HALT.
  - The counter clears on entry to MEMORY.
- MEMORY for any other icode: single cycle; mem_ready and dmem_error are ignored.
- WRITEBACK → PCUPD unconditionally.
- PCUPD: load the new PC, increment instr_count (wraps modulo 2^32), go to FETCH.
  - icode 8 → valC
  - icode 7 with latched cnd=1 → valC
  - icode 9 → latched valM
  - otherwise → latched valP
- HALT is sticky until reset. PC, stat and instr_count are frozen.
- The instruction that halts (halt or error) is not counted.

## Timing
- Non-memory instruction: exactly 6 cycles, FETCH through PCUPD. The new PC is visible the cycle after PCUPD, coinciding with f_en=1.
- Memory instruction: 6 + W cycles, where W is the number of MEMORY cycles with mem_ready=0. mem_ready high on the first MEMORY cycle gives W=0.
- Timeout: HALT is entered after MEM_TIMEOUT cycles in MEMORY with mem_ready=0, so m_en is high for exactly MEM_TIMEOUT cycles.
- Fetch inputs only need to be stable during FETCH. PC is constant from FETCH through PCUPD.
- stat and halted update on the same edge that enters HALT.
- Simultaneous imem_error and !instr_valid report ADR.
- mem_ready and dmem_error arriving on the timeout cycle count as a completed access, not a timeout.

## Test plan
- Reset: assert reset for 2 cycles mid-EXECUTE → PC=RESET_PC, stat=00, halted=0, instr_count=0, f_en=1 on the next cycle.
- Two nops (icode 1, valP=PC+1) from PC=0 → PC=1 after 6 cycles, PC=2 after 12 cycles, instr_count=2.
- jXX (icode 7, valC=0x40, valP=9):
  - with cnd=1 → PC=0x40
  - repeated with cnd=0 → PC=9
- ret (icode 9) with mem_ready delayed 3 cycles and valM=0x100 → m_en high for 4 cycles, PC=0x100 after 9 cycles.
- halt (icode 0) at PC=0x20 → stat=01 and halted=1 after the FETCH cycle; PC stays 0x20, all enables 0, unchanged through 20 further cycles.
- Errors:
  - imem_error=1 in FETCH → stat=10.
  - instr_valid=0 → stat=11.
  - mrmovq with MEM_TIMEOUT=8 and mem_ready held 0 → stat=10 after 8 MEMORY cycles; instr_count unchanged.
